// File: rtl/cocc_pkg.sv
// Shared COCC datapath definitions: default word width and the stack op encoding.
// An op is the concatenation {push, pop}.
package cocc_pkg;
  localparam int WORD_W = 8;

  typedef logic [1:0] stack_op_t;

  localparam stack_op_t OP_NONE = 2'b00;
  localparam stack_op_t OP_POP  = 2'b01;
  localparam stack_op_t OP_PUSH = 2'b10;
  localparam stack_op_t OP_REPL = 2'b11;
endpackage

// File: rtl/bus_stack_ptr.sv
// Saturating up/down entry counter for bus_stack.
// A refused inc (at DEPTH) or dec (at 0) holds the count; inc and dec together also hold it.
module stack_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam logic [PTR_W-1:0] ONE     = 1;
  localparam logic [PTR_W-1:0] DEPTH_C = DEPTH[PTR_W-1:0];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   count <= '0;
    else if (inc && !dec && !full)  count <= count + ONE;
    else if (dec && !inc && !empty) count <= count - ONE;
  end
endmodule

// File: rtl/bus_stack.sv
// LIFO register stack on the shared data bus with full/empty, sticky errors and push+pop replace.
// Optional feature: define BUS_STACK_PEEK_EN to add the peek_idx/peek_data random-read port.
module bus_stack
  import cocc_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_err,
  input  logic             oe,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
`ifdef BUS_STACK_PEEK_EN
  input  logic [PTR_W-2:0] peek_idx,
  output logic [WIDTH-1:0] peek_data,
`endif
  output logic             underflow
);
  localparam logic [PTR_W-2:0] ONE_IDX = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  stack_op_t        op;
  logic             inc, dec, wr_en, ovf_set, unf_set;
  logic [PTR_W-2:0] wr_idx, top_idx;

  stack_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .dec     (dec),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Low bits wrap to DEPTH-1 when count == DEPTH, which is exactly the top slot.
  assign top_idx = count[PTR_W-2:0] - ONE_IDX;
  assign op      = {push, pop};

  always_comb begin
    inc     = 1'b0;
    dec     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = count[PTR_W-2:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          wr_en = 1'b1;
          inc   = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) dec = 1'b1;
        else        unf_set = 1'b1;
      end
      OP_REPL: begin
        wr_en = 1'b1;
        if (!empty) wr_idx = top_idx;
        else        inc    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= din;
  end

  // A same-cycle error beats clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_err) || ovf_set;
      underflow <= (underflow && !clear_err) || unf_set;
    end
  end

  assign top  = empty ? '0 : mem[top_idx];
  assign dout = oe ? top : {WIDTH{1'bz}};

`ifdef BUS_STACK_PEEK_EN
  logic [PTR_W-2:0] peek_pos;
  assign peek_pos  = top_idx - peek_idx;
  assign peek_data = ({1'b0, peek_idx} < count) ? mem[peek_pos] : '0;
`endif
endmodule

// File: tb/tb_bus_stack.sv
// Randomized self-checking bench for bus_stack against a queue-based LIFO model.
// Build with BUS_STACK_PEEK_EN defined to also exercise the peek port.
module tb_bus_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic             clk = 0;
  logic             reset_n = 0;
  logic             push = 0, pop = 0, clear_err = 0, oe = 0;
  logic [WIDTH-1:0] din = '0;
  wire  [WIDTH-1:0] dout;
  logic [WIDTH-1:0] top;
  logic [PTR_W-1:0] count;
  logic             full, empty, overflow, underflow;
  logic             tb_en = 0;
  logic [WIDTH-1:0] tb_val = 8'hC3;
`ifdef BUS_STACK_PEEK_EN
  logic [PTR_W-2:0] peek_idx = '0;
  logic [WIDTH-1:0] peek_data;
`endif

  // Bench-side bus driver: only enabled while the DUT has oe low.
  assign dout = tb_en ? tb_val : {WIDTH{1'bz}};

  bus_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clear_err (clear_err),
    .oe        (oe),
    .din       (din),
    .dout      (dout),
    .top       (top),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
`ifdef BUS_STACK_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
`endif
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int q[$];
  bit m_ovf = 0, m_unf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_top();
    return (q.size() == 0) ? 0 : q[q.size()-1];
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".top"},       32'(top),       32'(exp_top()));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Model of one clocked operation, straight from the LIFO rules.
  task automatic model_op(input bit p, input bit o, input bit c, input int d);
    bit e_ovf = 0, e_unf = 0;
    if (p && !o) begin
      if (q.size() == DEPTH) e_ovf = 1; else q.push_back(d);
    end else if (o && !p) begin
      if (q.size() == 0) e_unf = 1; else void'(q.pop_back());
    end else if (p && o) begin
      if (q.size() == 0) q.push_back(d); else q[q.size()-1] = d;
    end
    m_ovf = (m_ovf && !c) || e_ovf;
    m_unf = (m_unf && !c) || e_unf;
  endtask

  task automatic op(input string tag, input bit p, input bit o, input bit c, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = o; clear_err = c; din = d;
    @(posedge clk);
    #1;
    push = 0; pop = 0; clear_err = 0;
    model_op(p, o, c, int'(d));
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #2;
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.top",   32'(top),   0);
    reset_n = 1;
    q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic check_bus(input string tag);
    @(negedge clk);
    oe = 1; tb_en = 0;
    #1 check({tag, ".dout_oe"}, 32'(dout), 32'(exp_top()));
    oe = 0; tb_en = 1;
    #1 check({tag, ".dout_released"}, 32'(dout), 32'(tb_val));
    tb_en = 0;
  endtask

  initial begin
    #12;
    check_state("reset");
    reset_n = 1;

    // 1: basic pushes and bus drive
    op("t1.p0", 1, 0, 0, 8'h11);
    op("t1.p1", 1, 0, 0, 8'h22);
    op("t1.p2", 1, 0, 0, 8'h33);
    check_bus("t1");

    // 2: fill, overflow, clear
    do_reset();
    for (int i = 1; i <= DEPTH; i++) op("t2.fill", 1, 0, 0, 8'(i));
    op("t2.ovf", 1, 0, 0, 8'hFF);
    op("t2.clr", 0, 0, 1, 8'h00);

    // 3: underflow is sticky through a later push
    do_reset();
    op("t3.unf", 0, 1, 0, 8'h00);
    op("t3.push", 1, 0, 0, 8'h5A);

    // 4: replace top, then pop
    do_reset();
    op("t4.p0", 1, 0, 0, 8'h10);
    op("t4.p1", 1, 0, 0, 8'h20);
    op("t4.repl", 1, 1, 0, 8'h99);
    op("t4.pop", 0, 1, 0, 8'h00);

    // 5: async reset mid-sequence
    for (int i = 0; i < 4; i++) op("t5.fill", 1, 0, 0, 8'(8'h40 + i));
    do_reset();
    op("t5.push", 1, 0, 0, 8'hAB);

`ifdef BUS_STACK_PEEK_EN
    // 6: peek
    do_reset();
    op("t6.p0", 1, 0, 0, 8'h10);
    op("t6.p1", 1, 0, 0, 8'h20);
    op("t6.p2", 1, 0, 0, 8'h30);
    peek_idx = 0; #1 check("t6.peek0", 32'(peek_data), 32'h30);
    peek_idx = 2; #1 check("t6.peek2", 32'(peek_data), 32'h10);
    peek_idx = 3; #1 check("t6.peek3", 32'(peek_data), 32'h00);
`endif

    // Random phase: biased toward the full and empty boundaries by drifting push rate.
    for (int i = 0; i < 600; i++) begin
      int  r    = int'($urandom_range(0, 99));
      int  bias = ((i / 100) % 2 == 0) ? 60 : 30;
      bit  p, o, c;
      p = (r < bias);
      o = (int'($urandom_range(0, 99)) < (100 - bias));
      c = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 79) == 0) do_reset();
      op("rnd", p, o, c, 8'($urandom));
      if ($urandom_range(0, 9) == 0) check_bus("rnd");
`ifdef BUS_STACK_PEEK_EN
      begin
        int pi = int'($urandom_range(0, DEPTH-1));
        peek_idx = PTR_W'(pi);
        #1 check("rnd.peek", 32'(peek_data),
                 32'((pi < q.size()) ? q[q.size()-1-pi] : 0));
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
